// File: rtl/wb_mac_pkg.sv
// Shared constants and helpers for the wb_mac_array Wishbone MAC accelerator.
package wb_mac_pkg;

    typedef enum logic {
        WB_IDLE,
        WB_ACK
    } wb_state_t;

    // Word offsets, i.e. wbs_adr_i[7:2]
    localparam logic [5:0] OFF_CTRL   = 6'h00;
    localparam logic [5:0] OFF_A      = 6'h01;
    localparam logic [5:0] OFF_B      = 6'h02;
    localparam logic [5:0] OFF_ACC_LO = 6'h03;
    localparam logic [5:0] OFF_ACC_HI = 6'h04;
    localparam logic [5:0] OFF_STATUS = 6'h05;
    localparam logic [5:0] OFF_THRESH = 6'h06;

    localparam int CTRL_CLR    = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int ST_BUSY     = 0;
    localparam int ST_OVF      = 1;
    localparam int ST_IRQ      = 2;

    function automatic int sum_w(input int dw, input int lanes);
        return 2 * dw + $clog2(lanes);
    endfunction

    function automatic logic [31:0] byte_merge(input logic [31:0] old, input logic [31:0] dat,
                                               input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int unsigned i = 0; i < 4; i++) begin
            if (sel[i]) r[i*8 +: 8] = dat[i*8 +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/mac_lane_tree.sv
// Lane multipliers (S1) and registered adder tree (S2) with valid pass-through.
module mac_lane_tree
    import wb_mac_pkg::*;
#(
    parameter int DW    = 8,
    parameter int LANES = 4,
    parameter int SUM_W = 18
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    input  logic [LANES*DW-1:0]     a,
    input  logic [LANES*DW-1:0]     b,
    output logic                    s1_valid,
    output logic                    out_valid,
    output logic signed [SUM_W-1:0] sum
);

    logic signed [2*DW-1:0]  prod [LANES];
    logic signed [SUM_W-1:0] sum_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            for (int unsigned i = 0; i < LANES; i++) prod[i] <= '0;
        end else begin
            s1_valid <= in_valid && !flush;
            if (in_valid) begin
                for (int unsigned i = 0; i < LANES; i++) begin
                    prod[i] <= (2*DW)'($signed(a[i*DW +: DW])) * (2*DW)'($signed(b[i*DW +: DW]));
                end
            end
        end
    end

    always_comb begin
        sum_c = '0;
        for (int unsigned i = 0; i < LANES; i++) sum_c = sum_c + SUM_W'(prod[i]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum       <= '0;
        end else begin
            out_valid <= s1_valid && !flush;
            if (s1_valid) sum <= sum_c;
        end
    end

endmodule

// File: rtl/wb_mac_array.sv
// Wishbone-slave dot-product MAC: register file, accumulator, threshold IRQ.
// Build option MAC_SAT_EN: saturate the accumulator on overflow instead of wrapping.
module wb_mac_array
    import wb_mac_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          DW        = 8,
    parameter int          LANES     = 4,
    parameter int          ACC_W     = 40
)(
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_adr_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        irq,
    output logic        mac_busy_o
);

    localparam int SUM_W = sum_w(DW, LANES);
    localparam int ADD_W = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 1;

    if (LANES * DW != 32) begin : g_bad_width
        $error("wb_mac_array: LANES*DW must equal 32");
    end
    if (ACC_W < 17 || ACC_W > 64) begin : g_bad_acc
        $error("wb_mac_array: ACC_W must be within 17..64");
    end

    wb_state_t state;

    logic [31:0]             a_reg, b_reg, b_next, rd_mux;
    logic [15:0]             thresh, cnt, cnt_next;
    logic                    irq_en, ovf, irq_pend, irq_set;
    logic signed [ACC_W-1:0] acc, acc_wrap, acc_next;
    logic signed [63:0]      acc_ext;
    logic signed [ADD_W-1:0] add_full;
    logic                    add_ovf;
    logic                    s1_valid, s2_valid;
    logic signed [SUM_W-1:0] sum;
    logic [5:0]              off;
    logic                    in_win, start, wr, launch, clr, w1c;
    logic [1:0]              unused_adr;

    assign off        = wbs_adr_i[7:2];
    assign unused_adr = wbs_adr_i[1:0];
    assign in_win     = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign start      = (state == WB_IDLE) && wbs_stb_i && wbs_cyc_i && in_win;
    assign wr         = start && wbs_we_i;
    assign b_next     = byte_merge(b_reg, wbs_dat_i, wbs_sel_i);
    assign launch     = wr && (off == OFF_B);
    assign clr        = wr && (off == OFF_CTRL) && wbs_sel_i[0] && wbs_dat_i[CTRL_CLR];
    assign w1c        = wr && (off == OFF_STATUS) && wbs_dat_i[ST_IRQ];

    // The launching op sees the B value being written this cycle
    mac_lane_tree #(.DW(DW), .LANES(LANES), .SUM_W(SUM_W)) u_tree (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .flush     (clr),
        .in_valid  (launch),
        .a         (a_reg),
        .b         (b_next),
        .s1_valid  (s1_valid),
        .out_valid (s2_valid),
        .sum       (sum)
    );

    always_comb begin
        add_full = ADD_W'(acc) + ADD_W'(sum);
        acc_wrap = add_full[ACC_W-1:0];
        add_ovf  = (ADD_W'(acc_wrap) != add_full);
`ifdef MAC_SAT_EN
        if (add_ovf) acc_next = add_full[ADD_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                                  : {1'b0, {(ACC_W-1){1'b1}}};
        else         acc_next = acc_wrap;
`else
        acc_next = acc_wrap;
`endif
    end

    assign cnt_next = cnt + 16'd1;
    assign irq_set  = s2_valid && (cnt_next == thresh) && (thresh != '0);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            acc      <= '0;
            cnt      <= '0;
            ovf      <= 1'b0;
            irq_pend <= 1'b0;
        end else if (clr) begin
            acc      <= '0;
            cnt      <= '0;
            ovf      <= 1'b0;
            irq_pend <= 1'b0;
        end else begin
            if (s2_valid) begin
                acc <= acc_next;
                cnt <= cnt_next;
                if (add_ovf) ovf <= 1'b1;
            end
            if (irq_set)  irq_pend <= 1'b1;
            else if (w1c) irq_pend <= 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            a_reg  <= '0;
            b_reg  <= '0;
            thresh <= '0;
            irq_en <= 1'b0;
        end else if (wr) begin
            case (off)
                OFF_CTRL:   if (wbs_sel_i[0]) irq_en <= wbs_dat_i[CTRL_IRQ_EN];
                OFF_A:      a_reg <= byte_merge(a_reg, wbs_dat_i, wbs_sel_i);
                OFF_B:      b_reg <= b_next;
                OFF_THRESH: begin
                    if (wbs_sel_i[0]) thresh[7:0]  <= wbs_dat_i[7:0];
                    if (wbs_sel_i[1]) thresh[15:8] <= wbs_dat_i[15:8];
                end
                default: ;
            endcase
        end
    end

    assign acc_ext = 64'(acc);

    always_comb begin
        rd_mux = '0;
        case (off)
            OFF_CTRL:   rd_mux[CTRL_IRQ_EN] = irq_en;
            OFF_A:      rd_mux = a_reg;
            OFF_B:      rd_mux = b_reg;
            OFF_ACC_LO: rd_mux = acc_ext[31:0];
            OFF_ACC_HI: rd_mux = acc_ext[63:32];
            OFF_STATUS: begin
                rd_mux[31:16]   = cnt;
                rd_mux[ST_IRQ]  = irq_pend;
                rd_mux[ST_OVF]  = ovf;
                rd_mux[ST_BUSY] = mac_busy_o;
            end
            OFF_THRESH: rd_mux[15:0] = thresh;
            default: ;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state     <= WB_IDLE;
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            case (state)
                WB_IDLE: if (start) begin
                    state     <= WB_ACK;
                    wbs_ack_o <= 1'b1;
                    if (!wbs_we_i) wbs_dat_o <= rd_mux;
                end
                WB_ACK: begin
                    state     <= WB_IDLE;
                    wbs_ack_o <= 1'b0;
                end
                default: state <= WB_IDLE;
            endcase
        end
    end

    assign mac_busy_o = s1_valid | s2_valid;
    assign irq        = irq_pend & irq_en;

endmodule

// File: tb/tb_wb_mac_array.sv
// Self-checking bench for wb_mac_array: ACC_W=40 and ACC_W=17 instances on one bus.
module tb_wb_mac_array;
    import wb_mac_pkg::*;

    logic        clk, rst, stb, cyc, we;
    logic [3:0]  sel;
    logic [31:0] dat, adr;
    logic        ack0, irq0, busy0, ack1, irq1, busy1;
    logic [31:0] dout0, dout1;

    int checks   = 0;
    int failures = 0;

    wb_mac_array dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_dat_i(dat), .wbs_adr_i(adr), .wbs_ack_o(ack0),
        .wbs_dat_o(dout0), .irq(irq0), .mac_busy_o(busy0)
    );

    wb_mac_array #(.ACC_W(17)) dut17 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_dat_i(dat), .wbs_adr_i(adr), .wbs_ack_o(ack1),
        .wbs_dat_o(dout1), .irq(irq1), .mac_busy_o(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    // Reference model: index 0 = ACC_W 40, index 1 = ACC_W 17
    logic [31:0] m_a, m_b;
    logic [15:0] m_thresh, m_cnt;
    logic        m_irq_en, m_pend;
    longint      m_acc [2];
    bit          m_ovf [2];
    int          acc_w [2] = '{40, 17};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_a = '0; m_b = '0; m_thresh = '0; m_cnt = '0; m_irq_en = 0; m_pend = 0;
        for (int k = 0; k < 2; k++) begin m_acc[k] = 0; m_ovf[k] = 0; end
    endtask

    task automatic model_clear();
        m_cnt = '0; m_pend = 0;
        for (int k = 0; k < 2; k++) begin m_acc[k] = 0; m_ovf[k] = 0; end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (s[i]) r[i*8 +: 8] = d[i*8 +: 8];
        return r;
    endfunction

    task automatic model_op();
        longint s;
        byte    sa, sb;
        s = 0;
        for (int i = 0; i < 4; i++) begin
            sa = m_a[i*8 +: 8];
            sb = m_b[i*8 +: 8];
            s += longint'(sa) * longint'(sb);
        end
        for (int k = 0; k < 2; k++) begin
            longint lim, full, r;
            lim  = longint'(1) << (acc_w[k] - 1);
            full = m_acc[k] + s;
            if (full > lim - 1 || full < -lim) begin
                m_ovf[k] = 1;
`ifdef MAC_SAT_EN
                r = (full < 0) ? -lim : lim - 1;
`else
                r = full & (2 * lim - 1);
                if (r >= lim) r -= 2 * lim;
`endif
            end else begin
                r = full;
            end
            m_acc[k] = r;
        end
        m_cnt++;
        if (m_cnt == m_thresh && m_thresh != 0) m_pend = 1;
    endtask

    task automatic model_write(input logic [5:0] off, input logic [31:0] d, input logic [3:0] s);
        case (off)
            OFF_CTRL: if (s[0]) begin
                m_irq_en = d[1];
                if (d[0]) model_clear();
            end
            OFF_A:      m_a = merge(m_a, d, s);
            OFF_B:      begin m_b = merge(m_b, d, s); model_op(); end
            OFF_STATUS: if (d[2]) m_pend = 0;
            OFF_THRESH: begin
                logic [31:0] t;
                t = merge({16'h0, m_thresh}, d, {2'b00, s[1:0]});
                m_thresh = t[15:0];
            end
            default: ;
        endcase
    endtask

    function automatic logic [31:0] exp_read(input logic [5:0] off, input int k);
        logic [63:0] av;
        av = m_acc[k];
        case (off)
            OFF_CTRL:   return {30'd0, m_irq_en, 1'b0};
            OFF_A:      return m_a;
            OFF_B:      return m_b;
            OFF_ACC_LO: return av[31:0];
            OFF_ACC_HI: return av[63:32];
            OFF_STATUS: return {m_cnt, 13'd0, m_pend, m_ovf[k], 1'b0};
            OFF_THRESH: return {16'd0, m_thresh};
            default:    return 32'd0;
        endcase
    endfunction

    task automatic bus(input bit w, input logic [5:0] off, input logic [31:0] d,
                       input logic [3:0] s, input bit keep,
                       output logic [31:0] r0, output logic [31:0] r1);
        int unsigned n;
        @(negedge clk);
        stb = 1; cyc = 1; we = w; adr = {24'h300000, off, 2'b00}; dat = d; sel = s;
        n = 0;
        do begin @(negedge clk); n++; end while (!ack0 && n < 16);
        check("ack_latency", 64'(n), 64'd1);
        check("ack17", {63'd0, ack1}, 64'd1);
        r0 = dout0;
        r1 = dout1;
        if (!keep) begin
            stb = 0; cyc = 0; we = 0;
            @(negedge clk);
            check("ack_one_cycle", {63'd0, ack0}, 64'd0);
        end
    endtask

    task automatic wr(input logic [5:0] off, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r0, r1;
        bus(1, off, d, s, 0, r0, r1);
        model_write(off, d, s);
    endtask

    task automatic rd_check(input logic [5:0] off, input string name);
        logic [31:0] r0, r1;
        bus(0, off, 32'd0, 4'hF, 0, r0, r1);
        check({name, "_w40"}, {32'd0, r0}, {32'd0, exp_read(off, 0)});
        check({name, "_w17"}, {32'd0, r1}, {32'd0, exp_read(off, 1)});
    endtask

    task automatic wait_idle();
        int unsigned n;
        n = 0;
        while ((busy0 || busy1) && n < 10) begin @(negedge clk); n++; end
        check("busy_timeout", {62'd0, busy0, busy1}, 64'd0);
    endtask

    task automatic read_all(input string name);
        for (int o = 0; o < 7; o++) rd_check(6'(o), name);
    endtask

    typedef struct {
        logic [31:0] a, b, lo40, hi40, lo17;
        logic        ovf17;
    } vec_t;

    initial begin
        vec_t        vt [4];
        logic [31:0] r0, r1, prev;
        int unsigned cnt_ack;

        vt[0] = '{32'h01020304, 32'h05060708, 32'h00000046, 32'h00000000, 32'h00000046, 1'b0};
        vt[1] = '{32'hFFFFFFFF, 32'h7F7F7F7F, 32'hFFFFFE04, 32'hFFFFFFFF, 32'hFFFFFE04, 1'b0};
`ifdef MAC_SAT_EN
        vt[2] = '{32'h80808080, 32'h80808080, 32'h00010000, 32'h00000000, 32'h0000FFFF, 1'b1};
`else
        vt[2] = '{32'h80808080, 32'h80808080, 32'h00010000, 32'h00000000, 32'hFFFF0000, 1'b1};
`endif
        vt[3] = '{32'h7F7F7F7F, 32'h80808080, 32'hFFFF0200, 32'hFFFFFFFF, 32'hFFFF0200, 1'b0};

        rst = 1; stb = 0; cyc = 0; we = 0; sel = 4'h0; dat = '0; adr = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_outputs", {60'd0, ack0, irq0, busy0, ack1}, 64'd0);
        check("reset_dat", {dout0, dout1}, 64'd0);
        rst = 0;
        read_all("reset_reg");

        // Table: one op from a cleared accumulator per vector
        for (int i = 0; i < 4; i++) begin
            wr(OFF_CTRL, 32'h1, 4'hF);
            wr(OFF_A, vt[i].a, 4'hF);
            wr(OFF_B, vt[i].b, 4'hF);
            check("busy_in_flight", {63'd0, busy0}, 64'd1);
            wait_idle();
            bus(0, OFF_ACC_LO, 0, 4'hF, 0, r0, r1);
            check("vec_acc_lo40", {32'd0, r0}, {32'd0, vt[i].lo40});
            check("vec_acc_lo17", {32'd0, r1}, {32'd0, vt[i].lo17});
            bus(0, OFF_ACC_HI, 0, 4'hF, 0, r0, r1);
            check("vec_acc_hi40", {32'd0, r0}, {32'd0, vt[i].hi40});
            bus(0, OFF_STATUS, 0, 4'hF, 0, r0, r1);
            check("vec_cnt", {48'd0, r0[31:16]}, 64'd1);
            check("vec_ovf17", {63'd0, r1[1]}, {63'd0, vt[i].ovf17});
        end

        // Two 0x80 ops: 17-bit overflows on the first, then sat stays / wrap returns to 0
        wr(OFF_CTRL, 32'h1, 4'hF);
        wr(OFF_A, 32'h80808080, 4'hF);
        wr(OFF_B, 32'h80808080, 4'hF);
        wait_idle();
        wr(OFF_B, 32'h80808080, 4'hF);
        wait_idle();
        bus(0, OFF_ACC_LO, 0, 4'hF, 0, r0, r1);
        check("twice_lo40", {32'd0, r0}, 64'h20000);
`ifdef MAC_SAT_EN
        check("twice_lo17", {32'd0, r1}, 64'h0000FFFF);
`else
        check("twice_lo17", {32'd0, r1}, 64'h0);
`endif
        rd_check(OFF_STATUS, "twice_status");

        // Read issued while the op is in flight returns the committed value
        prev = m_acc[0][31:0];
        bus(1, OFF_B, 32'h01010101, 4'hF, 1, r0, r1);
        model_write(OFF_B, 32'h01010101, 4'hF);
        bus(0, OFF_ACC_LO, 0, 4'hF, 0, r0, r1);
        check("read_during_busy", {32'd0, r0}, {32'd0, prev});
        wait_idle();
        rd_check(OFF_ACC_LO, "after_busy");

        // IRQ at threshold 3
        wr(OFF_CTRL, 32'h1, 4'hF);
        wr(OFF_THRESH, 32'h3, 4'hF);
        wr(OFF_CTRL, 32'h2, 4'hF);
        wr(OFF_A, 32'h01020304, 4'hF);
        for (int i = 0; i < 3; i++) begin
            wr(OFF_B, 32'h05060708, 4'hF);
            if (i == 2) check("irq_before_commit", {63'd0, irq0}, 64'd0);
            wait_idle();
            check("irq_step", {62'd0, irq0, irq1}, {62'd0, {2{m_pend & m_irq_en}}});
        end
        check("irq_raised", {63'd0, irq0}, 64'd1);
        wr(OFF_STATUS, 32'h4, 4'hF);
        check("irq_cleared", {63'd0, irq0}, 64'd0);
        rd_check(OFF_STATUS, "irq_status");

        // IRQ set and W1C on the same edge: set wins (model skips the W1C)
        wr(OFF_CTRL, 32'h3, 4'hF);
        wr(OFF_THRESH, 32'h1, 4'hF);
        bus(1, OFF_B, 32'h05060708, 4'hF, 1, r0, r1);
        model_write(OFF_B, 32'h05060708, 4'hF);
        bus(1, OFF_STATUS, 32'h4, 4'hF, 0, r0, r1);
        wait_idle();
        check("set_beats_w1c", {63'd0, irq0}, 64'd1);
        rd_check(OFF_STATUS, "set_wins_status");

        // CLR lands on the commit edge of an in-flight op: op discarded
        wr(OFF_THRESH, 32'h0, 4'hF);
        wr(OFF_B, 32'h05060708, 4'hF);
        wait_idle();
        bus(1, OFF_B, 32'h05060708, 4'hF, 1, r0, r1);
        model_write(OFF_B, 32'h05060708, 4'hF);
        wr(OFF_CTRL, 32'h1, 4'hF);
        repeat (4) @(negedge clk);
        bus(0, OFF_ACC_LO, 0, 4'hF, 0, r0, r1);
        check("clr_kill_acc", {32'd0, r0}, 64'd0);
        bus(0, OFF_STATUS, 0, 4'hF, 0, r0, r1);
        check("clr_kill_status", {32'd0, r0}, 64'd0);
        wr(OFF_B, 32'h05060708, 4'hF);
        wait_idle();
        rd_check(OFF_ACC_LO, "op_after_clr");

        // Unmapped in-window offsets ack, read 0, ignore writes
        wr(6'h07, 32'hDEADBEEF, 4'hF);
        wr(6'h3F, 32'hDEADBEEF, 4'hF);
        rd_check(6'h07, "unmapped_07");
        rd_check(6'h20, "unmapped_20");

        // Randomised traffic against the model
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 5))
                0: wr(OFF_A, $urandom, 4'($urandom_range(1, 15)));
                1, 2: begin
                    wr(OFF_B, $urandom, 4'($urandom_range(1, 15)));
                    wait_idle();
                end
                3: rd_check(6'($urandom_range(0, 8)), "rand_read");
                4: begin
                    wr(OFF_THRESH, 32'(m_cnt + 16'($urandom_range(0, 3))), 4'h3);
                    wr(OFF_CTRL, {30'd0, 1'($urandom_range(0, 1)), 1'b0}, 4'h1);
                end
                default: begin
                    if ($urandom_range(0, 3) == 0) wr(OFF_CTRL, {30'd0, m_irq_en, 1'b1}, 4'h1);
                    else                           wr(OFF_STATUS, 32'h4, 4'hF);
                end
            endcase
            check("rand_irq", {62'd0, irq0, irq1}, {62'd0, {2{m_pend & m_irq_en}}});
        end
        read_all("rand_final");

        // Out-of-window access is never acked
        @(negedge clk);
        stb = 1; cyc = 1; we = 0; adr = 32'h3000_0100; sel = 4'hF;
        cnt_ack = 0;
        repeat (16) begin @(negedge clk); if (ack0 || ack1) cnt_ack++; end
        stb = 0; cyc = 0;
        check("out_of_window", 64'(cnt_ack), 64'd0);

        // Reset during ACK: ack drops asynchronously, registers clear
        wr(OFF_A, 32'h11223344, 4'hF);
        @(negedge clk);
        stb = 1; cyc = 1; we = 1; adr = {24'h300000, OFF_B, 2'b00}; dat = 32'h01010101;
        sel = 4'hF;
        @(negedge clk);
        check("ack_before_rst", {63'd0, ack0}, 64'd1);
        rst = 1;
        #1;
        check("ack_async_rst", {62'd0, ack0, ack1}, 64'd0);
        stb = 0; cyc = 0; we = 0;
        @(negedge clk);
        check("busy_async_rst", {62'd0, busy0, busy1}, 64'd0);
        rst = 0;
        model_reset();
        read_all("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
